// File: rtl/lut_writer.sv
// lut_writer: loads a DEPTH x DATA_W table from a valid/ready byte stream at auto-incrementing
// addresses and exposes the contents on a combinational address->data read port.
module lut_writer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wr_count,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] LEN_ZERO = '0;

   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   remaining;
   logic              handshake;
   logic [DATA_W-1:0] entries [DEPTH];

   assign in_ready  = (state == ST_LOAD);
   assign busy      = (state == ST_LOAD) || (state == ST_DONE);
   assign done      = (state == ST_DONE);
   assign handshake = in_valid && in_ready;

   // Reads see the registered table, so a same-cycle write shows up only after the edge.
   assign data = entries[address];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         remaining <= '0;
         wr_count  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ptr       <= start_addr;
                  remaining <= length;
                  wr_count  <= '0;
                  state     <= (length == LEN_ZERO) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (handshake) begin
                  // ptr is ADDR_W bits wide, so it wraps modulo DEPTH on its own.
                  ptr       <= ptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  wr_count  <= wr_count + 1'b1;
                  if (remaining == LEN_ONE) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the table is a register array, not a RAM macro, because reset must clear every entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (handshake) begin
         entries[ptr] <= in_data;
      end
   end

endmodule
